pool_flatten_layer: RTL and testbench

Binary 2x2 max-pool and flatten stage that sits directly upstream of the final classification layer. It accepts a binarized feature map one pixel per handshake in raster order and ORs each non-overlapping 2x2 window; for binary values, OR is the max. It packs the pooled bits into a flat vector sized for the final layer's `data_in`, then raises a level done flag that the final layer uses as its `en`.

---
 rtl/bnn_pkg.sv | 10 +
 rtl/raster_counter.sv | 30 +++
 rtl/pool_flatten_layer.sv | 81 ++++++++
 tb/tb_pool_flatten_layer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared image dimensions, flattened-size derivation and pooling FSM states.
package bnn_pkg;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  function automatic int out_bits(input int w, input int h);
    return (w / 2) * (h / 2);
  endfunction
  localparam int DEF_OUT_BITS = out_bits(DEF_IMG_W, DEF_IMG_H);
  typedef enum logic [1:0] {IDLE, FILL, DONE} pool_state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: row/column raster position counter, column-first, wraps after the last pixel.
module raster_counter #(
  parameter int W = 28,
  parameter int H = 28
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic [$clog2(H)-1:0] o_r,
  output logic [$clog2(W)-1:0] o_c,
  output logic                 o_last
);
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  logic w_c_end;
  assign w_c_end = o_c == CW'(W - 1);
  assign o_last = w_c_end && (o_r == RW'(H - 1));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      o_r <= '0;
      o_c <= '0;
    end else if (i_clr) begin
      o_r <= '0;
      o_c <= '0;
    end else if (i_inc) begin
      o_c <= w_c_end ? '0 : o_c + 1'b1;
      if (w_c_end) o_r <= o_last ? '0 : o_r + 1'b1;
    end
endmodule

// File: rtl/pool_flatten_layer.sv
// pool_flatten_layer: streaming binary 2x2 OR (max) pool, flattened into one vector
// with a level done flag for the downstream classifier.
module pool_flatten_layer
  import bnn_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int OUT_BITS = out_bits(IMG_W, IMG_H)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                pixel_valid,
  input  logic                pixel_in,
  output logic                pixel_ready,
  output logic [OUT_BITS-1:0] data_out,
  output logic                layer_2_done
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int LW = $clog2(IMG_W / 2 + 1);
  localparam int IW = $clog2(OUT_BITS + 1);
  pool_state_t        r_state;
  logic               r_pend;
  logic [IMG_W/2-1:0] r_linebuf;
  logic [RW-1:0]      w_r;
  logic [CW-1:0]      w_c;
  logic               w_last, w_acc, w_clr;
  logic [LW-1:0]      w_lb;
  logic [IW-1:0]      w_idx;
  assign pixel_ready = r_state == FILL;
  // en gating makes an abort edge refuse the pixel on offer
  assign w_acc = pixel_ready && pixel_valid && en;
  assign w_clr = (r_state == IDLE && en) || (r_state == FILL && !en);
  assign w_lb = LW'(w_c >> 1);
  assign w_idx = IW'(w_r >> 1) * IW'(IMG_W / 2) + IW'(w_lb);
  raster_counter #(.W(IMG_W), .H(IMG_H)) u_cnt (
    .clock (clock),
    .reset (reset),
    .i_clr (w_clr),
    .i_inc (w_acc),
    .o_r   (w_r),
    .o_c   (w_c),
    .o_last(w_last)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state      <= IDLE;
      r_pend       <= 1'b0;
      r_linebuf    <= '0;
      data_out     <= '0;
      layer_2_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (en) begin
          r_state   <= FILL;
          r_pend    <= 1'b0;
          r_linebuf <= '0;
          data_out  <= '0;
        end
        FILL: if (!en) begin
          r_state  <= IDLE;
          data_out <= '0;
        end else if (w_acc) begin
          // left pixel of a pair waits in pend; top pair result waits in the line buffer
          if (!w_c[0]) r_pend <= pixel_in;
          else if (!w_r[0]) r_linebuf[w_lb] <= r_pend | pixel_in;
          else data_out[w_idx] <= r_linebuf[w_lb] | r_pend | pixel_in;
          if (w_last) begin
            r_state      <= DONE;
            layer_2_done <= 1'b1;
          end
        end
        DONE: if (!en) begin
          r_state      <= IDLE;
          layer_2_done <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pool_flatten_layer.sv
// tb_pool_flatten_layer: directed frames against hand-computed and reference-pooled results.
module tb_pool_flatten_layer;
  localparam int W = 28, H = 28, NPIX = W * H, NB = (W / 2) * (H / 2);
  logic clock = 1'b0, reset = 1'b1, en = 1'b0, pixel_valid = 1'b0, pixel_in = 1'b0;
  logic pixel_ready, layer_2_done;
  logic [NB-1:0] data_out, exp_v, held;
  logic img [NPIX];
  int n_chk = 0, n_fail = 0;
  pool_flatten_layer dut (
    .clock(clock), .reset(reset), .en(en), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .pixel_ready(pixel_ready), .data_out(data_out), .layer_2_done(layer_2_done)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [NB-1:0] pool_ref();
    logic [NB-1:0] v = '0;
    for (int wr = 0; wr < H / 2; wr++)
      for (int wc = 0; wc < W / 2; wc++)
        for (int k = 0; k < 4; k++)
          v[wr * (W / 2) + wc] |= img[(2 * wr + k / 2) * W + 2 * wc + k % 2];
    return v;
  endfunction
  task automatic fill_img(input int mode);
    for (int i = 0; i < NPIX; i++)
      img[i] = mode == 1 ? 1'b1 : mode == 2 ? 1'($urandom) : 1'b0;
  endtask
  task automatic start();
    @(negedge clock);
    en = 1'b1;
    pixel_valid = 1'b0;
    #1 check("ready_low_in_idle", pixel_ready, 1'b0);
  endtask
  // offers img[from..to-1]; returns #1 after the edge accepting the last one
  task automatic feed(input int from, input int to, input bit gaps);
    int k = from, cyc = 0;
    bit acc;
    while (k < to && cyc < 5000) begin
      @(negedge clock);
      pixel_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pixel_in = pixel_valid ? img[k] : 1'($urandom);
      acc = pixel_valid && pixel_ready;
      @(posedge clock);
      if (acc) k++;
      cyc++;
    end
    #1;
    if (k < to) check("feed_timeout", k, to);
  endtask
  task automatic finish_frame(input string tag, input logic [NB-1:0] exp);
    check({tag, "_done"}, layer_2_done, 1'b1);
    check({tag, "_ready_low"}, pixel_ready, 1'b0);
    check({tag, "_data"}, data_out, exp);
    @(negedge clock);
    en = 1'b0;
    pixel_valid = 1'b0;
    @(posedge clock);
    #1 check({tag, "_done_fall"}, layer_2_done, 1'b0);
    check({tag, "_data_kept"}, data_out, exp);
  endtask
  initial begin
    #2 check("reset_data", data_out, '0);
    check("reset_done", layer_2_done, 1'b0);
    check("reset_ready", pixel_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    // all ones, valid held
    fill_img(1);
    start();
    feed(0, NPIX - 1, 1'b0);
    check("ones_done_before_last", layer_2_done, 1'b0);
    feed(NPIX - 1, NPIX, 1'b0);
    check("ones_done_on_last", layer_2_done, 1'b1);
    // DONE ignores further offers and holds data_out
    held = data_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      pixel_valid = 1'b1;
      pixel_in = 1'b0;
      @(posedge clock);
      #1 check("done_hold", data_out, held);
    end
    finish_frame("ones", {NB{1'b1}});
    // single 1 at r=3, c=5
    fill_img(0);
    img[3 * W + 5] = 1'b1;
    start();
    feed(0, NPIX, 1'b0);
    exp_v = '0;
    exp_v[16] = 1'b1;
    finish_frame("single", exp_v);
    // one 1 per window rotating through the four positions
    fill_img(0);
    for (int wr = 0; wr < H / 2; wr++)
      for (int wc = 0; wc < W / 2; wc++) begin
        int k = (wr * (W / 2) + wc) % 4;
        img[(2 * wr + k / 2) * W + 2 * wc + k % 2] = 1'b1;
      end
    start();
    feed(0, NPIX, 1'b0);
    finish_frame("checker", {NB{1'b1}});
    fill_img(0);
    start();
    feed(0, NPIX, 1'b0);
    finish_frame("zeros", '0);
    // random with valid gaps
    fill_img(2);
    start();
    feed(0, NPIX, 1'b1);
    finish_frame("random", pool_ref());
    // abort after 400 accepted pixels
    fill_img(1);
    start();
    feed(0, 400, 1'b0);
    check("abort_partial_bit0", data_out[0], 1'b1);
    @(negedge clock);
    en = 1'b0;
    pixel_valid = 1'b1;
    @(posedge clock);
    #1 check("abort_ready", pixel_ready, 1'b0);
    check("abort_data", data_out, '0);
    check("abort_done", layer_2_done, 1'b0);
    fill_img(2);
    start();
    feed(0, NPIX, 1'b1);
    finish_frame("after_abort", pool_ref());
    // en falls on the same edge as the last handshake: abort wins
    fill_img(1);
    start();
    feed(0, NPIX - 1, 1'b0);
    @(negedge clock);
    en = 1'b0;
    pixel_valid = 1'b1;
    pixel_in = 1'b1;
    @(posedge clock);
    #1 check("race_done", layer_2_done, 1'b0);
    check("race_data", data_out, '0);
    check("race_ready", pixel_ready, 1'b0);
    // asynchronous reset mid-frame
    start();
    feed(0, 300, 1'b0);
    @(negedge clock);
    pixel_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("areset_data", data_out, '0);
    check("areset_ready", pixel_ready, 1'b0);
    check("areset_done", layer_2_done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    fill_img(2);
    feed(0, NPIX, 1'b0);
    exp_v = pool_ref();
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1 check("post_reset_done_hold", layer_2_done, 1'b1);
    end
    finish_frame("post_reset", exp_v);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
